audio_frame_packer: RTL and testbench

Upstream feeder for the I2S transmitter. Accepts a 24-bit signed sample stream with valid/ready handshake, pairs left/right samples into one 48-bit stereo frame, applies per-channel gain with saturation, and writes the frame into the I2S audio FIFO while respecting its `full` flag. Output frame format is {left[47:24], right[23:0]}, matching the I2S transmitter's channel order: left first, right last.

---
 rtl/audio_frame_packer.sv | 169 ++++++++++++++++
 tb/tb_audio_frame_packer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_packer.sv
// audio_frame_packer
//
// Pairs a left/right 24-bit signed sample stream into one 48-bit stereo frame
// {left, right}, applies per-channel fixed-point gain with saturation (or mute),
// and writes the frame into the I2S audio FIFO, stalling while the FIFO is full.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   s_data            - 24-bit signed sample
//   s_last            - 0 = left sample, 1 = right sample (closes the pair)
//   s_valid / s_ready - sample handshake
//   gain_l, gain_r    - unsigned gains, GAIN_BITS-1 fraction bits, latched with the right sample
//   mute              - forces the frame to zero, latched with the right sample
//   frame_out         - registered frame to the FIFO data input
//   write_frame       - FIFO write strobe (combinational on full)
//   full              - FIFO full flag
//   sync_err          - one-cycle pulse after a left/right pairing error
module audio_frame_packer #(
    parameter int unsigned GAIN_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [23:0]          s_data,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [GAIN_BITS-1:0] gain_l,
    input  logic [GAIN_BITS-1:0] gain_r,
    input  logic                 mute,
    output logic [47:0]          frame_out,
    output logic                 write_frame,
    input  logic                 full,
    output logic                 sync_err
);

    localparam int unsigned ProdW = 24 + GAIN_BITS + 1;

    // Saturation bounds sign-extended to the product width.
    localparam logic signed [ProdW-1:0] SatHi = {{(ProdW - 24){1'b0}}, 24'h7FFFFF};
    localparam logic signed [ProdW-1:0] SatLo = {{(ProdW - 24){1'b1}}, 24'h800000};

    typedef enum logic [1:0] {
        StWaitL,
        StWaitR,
        StScale,
        StEmit
    } state_e;

    state_e                 state_q, state_d;
    logic [23:0]            left_hold_q, left_hold_d;
    logic [23:0]            right_hold_q, right_hold_d;
    logic [GAIN_BITS-1:0]   gain_l_q, gain_l_d;
    logic [GAIN_BITS-1:0]   gain_r_q, gain_r_d;
    logic                   mute_q, mute_d;
    logic [47:0]            frame_q, frame_d;
    logic                   sync_err_q, sync_err_d;
    logic                   handshake;

    // Signed sample times zero-extended gain, arithmetic shift, clamp to 24 bits.
    function automatic logic [23:0] apply_gain(input logic [23:0] sample,
                                               input logic [GAIN_BITS-1:0] gain);
        logic signed [ProdW-1:0] s_ext;
        logic signed [ProdW-1:0] g_ext;
        logic signed [ProdW-1:0] prod;
        logic signed [ProdW-1:0] q;
        s_ext = {{(GAIN_BITS + 1){sample[23]}}, sample};
        g_ext = {24'd0, 1'b0, gain};
        prod  = s_ext * g_ext;
        q     = prod >>> (GAIN_BITS - 1);
        if (q > SatHi) begin
            return 24'h7FFFFF;
        end else if (q < SatLo) begin
            return 24'h800000;
        end
        return q[23:0];
    endfunction

    assign handshake = s_valid && s_ready;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StWaitL;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            gain_l_q     <= '0;
            gain_r_q     <= '0;
            mute_q       <= 1'b0;
            frame_q      <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            gain_l_q     <= gain_l_d;
            gain_r_q     <= gain_r_d;
            mute_q       <= mute_d;
            frame_q      <= frame_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitL: if (handshake && !s_last) state_d = StWaitR;
            StWaitR: if (handshake && s_last) state_d = StScale;
            StScale: state_d = StEmit;
            StEmit:  if (!full) state_d = StWaitL;
            default: state_d = StWaitL;
        endcase
    end

    // Datapath next-state: capture samples, latch gains, scale, flag pairing errors.
    always_comb begin
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        gain_l_d     = gain_l_q;
        gain_r_d     = gain_r_q;
        mute_d       = mute_q;
        frame_d      = frame_q;
        sync_err_d   = 1'b0;
        unique case (state_q)
            StWaitL: begin
                if (handshake) begin
                    if (s_last) begin
                        sync_err_d = 1'b1;
                    end else begin
                        left_hold_d = s_data;
                    end
                end
            end
            StWaitR: begin
                if (handshake) begin
                    if (s_last) begin
                        right_hold_d = s_data;
                        gain_l_d     = gain_l;
                        gain_r_d     = gain_r;
                        mute_d       = mute;
                    end else begin
                        // Two lefts in a row: keep the newest as the left of the pair.
                        left_hold_d = s_data;
                        sync_err_d  = 1'b1;
                    end
                end
            end
            StScale: begin
                if (mute_q) begin
                    frame_d = '0;
                end else begin
                    frame_d = {apply_gain(left_hold_q, gain_l_q),
                               apply_gain(right_hold_q, gain_r_q)};
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        s_ready     = (state_q == StWaitL || state_q == StWaitR) && !reset;
        write_frame = (state_q == StEmit) && !full && !reset;
    end

    assign frame_out = frame_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed and randomized-streaming bench for audio_frame_packer.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_audio_frame_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  gain_l = 8'd128;
    logic [7:0]  gain_r = 8'd128;
    logic        mute = 1'b0;
    logic [47:0] frame_out;
    logic        write_frame;
    logic        full = 1'b0;
    logic        sync_err;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [47:0] got_q[$];

    always #5 clk = ~clk;

    audio_frame_packer #(.GAIN_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .gain_l     (gain_l),
        .gain_r     (gain_r),
        .mute       (mute),
        .frame_out  (frame_out),
        .write_frame(write_frame),
        .full       (full),
        .sync_err   (sync_err)
    );

    // FIFO-side monitor: whatever is presented with write_frame is captured at the next edge.
    always @(negedge clk) begin
        if (write_frame) begin
            wr_cnt++;
            got_q.push_back(frame_out);
        end
        if (sync_err) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference: integer multiply, floor shift, clamp.
    function automatic logic [23:0] model_gain(input logic [23:0] s, input int g);
        longint v;
        longint q;
        v = longint'($signed(s));
        q = (v * longint'(g)) >>> 7;
        if (q > 64'sd8388607) q = 64'sd8388607;
        if (q < -64'sd8388608) q = -64'sd8388608;
        return q[23:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted; returns 1 ns after the handshake edge.
    task automatic send(input logic [23:0] d, input logic last);
        bit hit;
        hit = 1'b0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            hit = s_ready;
            cyc();
        end
        s_valid = 1'b0;
        if (!hit) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: s_ready stayed 0 for data %h", d);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'h0ABCDE;
        s_last  = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_s_ready: got %b want 0", s_ready);
        end
        tests_run++;
        if (write_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_write_frame: got %b want 0", write_frame);
        end
        tests_run++;
        if (frame_out !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_frame_out: got %h want 0", frame_out);
        end
        tests_run++;
        if (sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sync_err: got %b want 0", sync_err);
        end
        cyc();
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_s_ready: got %b want 1", s_ready);
        end
        cyc();
    endtask

    task automatic test_unity();
        int base;
        base   = wr_cnt;
        gain_l = 8'd128;
        gain_r = 8'd128;
        mute   = 1'b0;
        full   = 1'b0;
        send(24'h123456, 1'b0);
        send(24'hFEDCBA, 1'b1);
        @(negedge clk);
        tests_run++;
        if (write_frame !== 1'b0 || s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity_scale_cycle: write=%b ready=%b want 0 0", write_frame, s_ready);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (write_frame !== 1'b1) begin
            tests_failed++;
            $display("FAIL unity_write_latency: got %b want 1", write_frame);
        end
        tests_run++;
        if (frame_out !== 48'h123456FEDCBA) begin
            tests_failed++;
            $display("FAIL unity_frame: got %h want 123456fedcba", frame_out);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (write_frame !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL unity_after_write: write=%b ready=%b want 0 1", write_frame, s_ready);
        end
        cyc();
        tests_run++;
        if (wr_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL unity_write_count: got %0d want 1", wr_cnt - base);
        end
    endtask

    task automatic test_saturation();
        int base;
        logic [47:0] last_f;
        base   = wr_cnt;
        gain_l = 8'd255;
        gain_r = 8'd255;
        send(24'h7FFFFF, 1'b0);
        send(24'h800000, 1'b1);
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (wr_cnt - base !== 1 || last_f !== 48'h7FFFFF800000) begin
            tests_failed++;
            $display("FAIL sat_255: writes %0d frame %h want 1 7fffff800000", wr_cnt - base, last_f);
        end
        base   = wr_cnt;
        gain_l = 8'd64;
        gain_r = 8'd64;
        send(24'h000100, 1'b0);
        send(24'hFFFF00, 1'b1);
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (wr_cnt - base !== 1 || last_f !== 48'h000080FFFF80) begin
            tests_failed++;
            $display("FAIL gain_64: writes %0d frame %h want 1 000080ffff80", wr_cnt - base, last_f);
        end
        base   = wr_cnt;
        gain_l = 8'd0;
        gain_r = 8'd0;
        send(24'h3FFFFF, 1'b0);
        send(24'hC00000, 1'b1);
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (wr_cnt - base !== 1 || last_f !== 48'h0) begin
            tests_failed++;
            $display("FAIL gain_0: writes %0d frame %h want 1 0", wr_cnt - base, last_f);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int bad;
        base   = wr_cnt;
        bad    = 0;
        gain_l = 8'd128;
        gain_r = 8'd128;
        send(24'h000200, 1'b0);
        send(24'h000300, 1'b1);
        full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            if (write_frame !== 1'b0 || s_ready !== 1'b0 || frame_out !== 48'h000200000300) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d bad cycles (write=%b ready=%b frame=%h) want 0",
                     bad, write_frame, s_ready, frame_out);
        end
        cyc();
        full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (write_frame !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_write: got %b want 1", write_frame);
        end
        repeat (3) cyc();
        tests_run++;
        if (wr_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL bp_write_count: got %0d want 1", wr_cnt - base);
        end
    endtask

    task automatic test_sync_err();
        int base_w;
        int base_e;
        logic [47:0] last_f;
        base_w = wr_cnt;
        base_e = err_cnt;
        gain_l = 8'd128;
        gain_r = 8'd128;
        send(24'h000111, 1'b1);
        @(negedge clk);
        tests_run++;
        if (sync_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL sync_r_first_pulse: got %b want 1", sync_err);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (sync_err !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sync_r_first_after: err=%b ready=%b want 0 1", sync_err, s_ready);
        end
        repeat (4) cyc();
        tests_run++;
        if (wr_cnt - base_w !== 0) begin
            tests_failed++;
            $display("FAIL sync_r_first_no_frame: got %0d writes want 0", wr_cnt - base_w);
        end
        base_e = err_cnt;
        send(24'd1, 1'b0);
        send(24'd2, 1'b0);
        send(24'd3, 1'b1);
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (err_cnt - base_e !== 1) begin
            tests_failed++;
            $display("FAIL resync_err_count: got %0d want 1", err_cnt - base_e);
        end
        tests_run++;
        if (wr_cnt - base_w !== 1 || last_f !== {24'd2, 24'd3}) begin
            tests_failed++;
            $display("FAIL resync_frame: writes %0d frame %h want 1 000002000003",
                     wr_cnt - base_w, last_f);
        end
    endtask

    task automatic test_mute();
        logic [47:0] last_f;
        gain_l = 8'd128;
        gain_r = 8'd128;
        mute   = 1'b0;
        send(24'h123456, 1'b0);
        mute = 1'b1;
        send(24'h654321, 1'b1);
        mute = 1'b0;
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (last_f !== 48'h0) begin
            tests_failed++;
            $display("FAIL mute_frame: got %h want 0", last_f);
        end
        // Changes right after the R handshake must not touch the in-flight frame.
        send(24'h010000, 1'b0);
        send(24'h020000, 1'b1);
        mute   = 1'b1;
        gain_l = 8'd0;
        gain_r = 8'd255;
        repeat (4) cyc();
        last_f = (got_q.size() > 0) ? got_q[$] : 48'hx;
        tests_run++;
        if (last_f !== 48'h010000020000) begin
            tests_failed++;
            $display("FAIL late_gain_change: got %h want 010000020000", last_f);
        end
        mute   = 1'b0;
        gain_l = 8'd128;
        gain_r = 8'd128;
    endtask

    task automatic test_reset_mid();
        int base_w;
        int base_e;
        base_w = wr_cnt;
        send(24'h00AAAA, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0 || write_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wait_r: ready=%b write=%b want 0 0", s_ready, write_frame);
        end
        cyc();
        reset  = 1'b0;
        base_e = err_cnt;
        send(24'h00BBBB, 1'b1);
        repeat (4) cyc();
        tests_run++;
        if (err_cnt - base_e !== 1 || wr_cnt - base_w !== 0) begin
            tests_failed++;
            $display("FAIL reset_then_r: errs %0d writes %0d want 1 0",
                     err_cnt - base_e, wr_cnt - base_w);
        end
        // Reset while a frame waits in EMIT discards it; full drops during reset.
        full = 1'b1;
        send(24'h000005, 1'b0);
        send(24'h000006, 1'b1);
        cyc();
        reset = 1'b1;
        full  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (write_frame !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_emit_write: got %b want 0", write_frame);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (frame_out !== 48'h0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_emit_state: frame %h ready %b want 0 1", frame_out, s_ready);
        end
        repeat (3) cyc();
        tests_run++;
        if (wr_cnt - base_w !== 0) begin
            tests_failed++;
            $display("FAIL reset_in_emit_dropped: got %0d writes want 0", wr_cnt - base_w);
        end
    endtask

    task automatic test_stream();
        logic [47:0] exp_q[$];
        logic [23:0] l;
        logic [23:0] r;
        logic [7:0]  gl;
        logic [7:0]  gr;
        logic        m;
        bit          done;
        int          base;
        int          bad;
        got_q.delete();
        base = wr_cnt;
        done = 1'b0;
        bad  = 0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    l  = 24'($urandom);
                    r  = 24'($urandom);
                    gl = 8'($urandom);
                    gr = 8'($urandom);
                    m  = ($urandom_range(0, 7) == 0);
                    repeat ($urandom_range(0, 2)) cyc();
                    send(l, 1'b0);
                    repeat ($urandom_range(0, 2)) cyc();
                    gain_l = gl;
                    gain_r = gr;
                    mute   = m;
                    send(r, 1'b1);
                    exp_q.push_back(m ? 48'h0 : {model_gain(l, int'(gl)), model_gain(r, int'(gr))});
                    gain_l = 8'($urandom);
                    gain_r = 8'($urandom);
                    mute   = 1'($urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    full = ($urandom_range(0, 3) == 0);
                    cyc();
                end
                full = 1'b0;
            end
        join
        for (int i = 0; i < 2000 && wr_cnt < base + 100; i++) cyc();
        tests_run++;
        if (wr_cnt - base !== 100) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d frames want 100", wr_cnt - base);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                tests_failed++;
                if (bad <= 5) begin
                    $display("FAIL stream_frame[%0d]: got %h want %h", i,
                             (i < got_q.size()) ? got_q[i] : 48'hx, exp_q[i]);
                end
            end
        end
        mute   = 1'b0;
        gain_l = 8'd128;
        gain_r = 8'd128;
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_backpressure();
        test_sync_err();
        test_mute();
        test_reset_mid();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
